// File: rtl/clk_tick_gen_pkg.sv
// clk_tick_gen_pkg: shared mode and channel-state encodings for the tick generator
package clk_tick_gen_pkg;
  typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/clk_tick_chan.sv
// clk_tick_chan: one programmable tick channel (divisor/mode regs, counter, run/idle FSM, tick reg)
module clk_tick_chan
  import clk_tick_gen_pkg::*;
#(
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = 5000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic             i_cfg_mode,
  input  logic             i_start,
  output logic             o_tick,
  output logic             o_busy
);
  logic [CNT_W-1:0] r_div, r_cnt, w_div, w_cnt;
  logic             r_mode, w_mode, r_tick, w_tick, w_term;
  state_e           r_state, w_state;

  // div==0 never terminates, so div-1 is never evaluated with wrap-around meaning
  assign w_term = (r_div != '0) && (r_cnt == r_div - CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= CNT_W'(DEFAULT_DIV);
      r_mode  <= MODE_PERIODIC;
      r_cnt   <= '0;
      r_state <= ST_RUN;
      r_tick  <= 1'b0;
    end else begin
      r_div   <= w_div;
      r_mode  <= w_mode;
      r_cnt   <= w_cnt;
      r_state <= w_state;
      r_tick  <= w_tick;
    end
  end

  // priority cfg > start > sync_clr > count; any restart swallows a coincident terminal tick
  always_comb begin
    w_div   = r_div;
    w_mode  = r_mode;
    w_cnt   = r_cnt;
    w_state = r_state;
    w_tick  = 1'b0;
    if (i_cfg_we) begin
      w_div   = i_cfg_div;
      w_mode  = i_cfg_mode;
      w_cnt   = '0;
      w_state = (i_cfg_div != '0) && (i_start || i_cfg_mode == MODE_PERIODIC) ? ST_RUN : ST_IDLE;
    end else if (i_start) begin
      w_cnt   = '0;
      w_state = (r_div != '0) ? ST_RUN : ST_IDLE;
    end else if (i_sync_clr) begin
      w_cnt   = '0;
    end else if (i_en && r_state == ST_RUN) begin
      w_cnt   = w_term ? '0 : r_cnt + CNT_W'(1);
      w_tick  = w_term;
      w_state = (w_term && r_mode == MODE_ONESHOT) ? ST_IDLE : ST_RUN;
    end
  end

  always_comb begin
    o_tick = r_tick;
    o_busy = (r_state == ST_RUN);
  end
endmodule

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: N_CH run-time programmable tick channels sharing one clock, enable and phase clear
module clk_tick_gen
  import clk_tick_gen_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = 5000,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic             i_cfg_mode,
  input  logic [N_CH-1:0]  i_start,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_busy
);
  logic [N_CH-1:0] w_we;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_we[g] = i_cfg_we && (i_cfg_ch == CH_W'(g));
    clk_tick_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .i_sync_clr (i_sync_clr),
      .i_cfg_we   (w_we[g]),
      .i_cfg_div  (i_cfg_div),
      .i_cfg_mode (i_cfg_mode),
      .i_start    (i_start[g]),
      .o_tick     (o_tick[g]),
      .o_busy     (o_busy[g])
    );
  end
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed plus random stimulus against a countdown reference model of every channel
module tb_clk_tick_gen;
  localparam int N = 4;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0, cfg_mode = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [20:0] cfg_div = '0;
  logic [N-1:0] start = '0, o_tick, o_busy;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_div[N], m_rem[N];
  logic [N-1:0] m_mode, m_arm, m_tick;
  int first_tick[N];

  clk_tick_gen #(.N_CH(N), .CNT_W(21), .DEFAULT_DIV(5000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync_clr(sync_clr), .i_cfg_we(cfg_we),
    .i_cfg_ch(cfg_ch), .i_cfg_div(cfg_div), .i_cfg_mode(cfg_mode), .i_start(start),
    .o_tick(o_tick), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_div[i] = 5000; m_rem[i] = 5000;
    end
    m_mode = '0; m_arm = '1; m_tick = '0;
  endtask

  // rem = enabled edges still needed before the next tick
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      m_tick[i] = 1'b0;
      if (cfg_we && int'(cfg_ch) == i) begin
        m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_rem[i] = m_div[i];
        m_arm[i] = (m_div[i] != 0) && (start[i] || !cfg_mode);
      end else if (start[i]) begin
        m_rem[i] = m_div[i]; m_arm[i] = (m_div[i] != 0);
      end else if (sync_clr) begin
        m_rem[i] = m_div[i];
      end else if (en && m_arm[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_tick[i] = 1'b1; m_rem[i] = m_div[i]; m_arm[i] = !m_mode[i];
        end
      end
    end
  endtask

  task automatic check(string tag);
    n_cmp += 2;
    assert (o_tick === m_tick) else begin
      n_bad++; $error("FAIL %s tick cyc=%0d got=%b exp=%b", tag, cyc, o_tick, m_tick);
    end
    assert (o_busy === m_arm) else begin
      n_bad++; $error("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, o_busy, m_arm);
    end
  endtask

  task automatic run(int n, string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check(tag);
      for (int i = 0; i < N; i++)
        if (o_tick[i] && first_tick[i] < 0) first_tick[i] = cyc;
      cfg_we = 1'b0; start = '0; sync_clr = 1'b0;
    end
  endtask

  task automatic cfg(int ch, int div, logic mode, logic st, string tag);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 21'(div); cfg_mode = mode;
    start[ch] = st;
    run(1, tag);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) first_tick[i] = -1;
    #12;
    check("reset");
    rst_n = 1'b1; en = 1'b1;
    run(5005, "defaults");
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      assert (first_tick[i] === 5000) else begin
        n_bad++; $error("FAIL first_tick ch%0d got=%0d exp=5000", i, first_tick[i]);
      end
    end
    cfg(1, 3, 1'b0, 1'b0, "ch1_div3");
    run(10, "ch1_div3");
    cfg(2, 4, 1'b1, 1'b0, "ch2_cfg");
    start[2] = 1'b1;
    run(10, "ch2_oneshot");
    cfg(3, 8, 1'b0, 1'b0, "ch3_div8");
    run(3, "ch3_div8");
    en = 1'b0;
    run(10, "en_low");
    en = 1'b1;
    run(12, "en_high");
    cfg(3, 1, 1'b0, 1'b0, "div1");
    run(5, "div1");
    cfg(0, 0, 1'b0, 1'b0, "div0");
    start[0] = 1'b1;
    run(6, "div0");
    cfg(1, 5, 1'b1, 1'b1, "cfg_start");
    run(7, "cfg_start");
    cfg(0, 6, 1'b0, 1'b0, "ch0_div6");
    run(2, "pre_sync");
    cfg(1, 6, 1'b0, 1'b0, "ch1_div6");
    run(3, "pre_sync");
    sync_clr = 1'b1;
    run(14, "sync_clr");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    #2 rst_n = 1'b1;
    run(20, "post_reset");
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(7) != 0);
      sync_clr = ($urandom_range(31) == 0);
      cfg_we = ($urandom_range(15) == 0);
      cfg_ch = 2'($urandom_range(3));
      cfg_div = 21'($urandom_range(9));
      cfg_mode = 1'($urandom_range(1));
      for (int i = 0; i < N; i++) start[i] = ($urandom_range(19) == 0);
      run(1, "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
